// File: rtl/buzzer_pattern.sv
// Piezo buzzer driver: programmable tone divider, continuous level mode
// and an N-beep pattern engine with start/busy/done handshake.
module buzzer_pattern #(
    parameter int DIV_W = 16,
    parameter int DUR_W = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             buzz,
    input  logic [DIV_W-1:0] tone_div,
    input  logic [DUR_W-1:0] on_ticks,
    input  logic [DUR_W-1:0] off_ticks,
    input  logic [CNT_W-1:0] beep_count,
    output logic             busy,
    output logic             done,
    output logic             buzzer_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONT = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_OFF  = 2'd3;

    localparam logic [DIV_W-1:0] ONE_DIV = DIV_W'(1);
    localparam logic [DUR_W-1:0] ONE_DUR = DUR_W'(1);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] tcnt_q, tcnt_d;
    logic [DUR_W-1:0] dcnt_q, dcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DUR_W-1:0] on_q, on_d;
    logic [DUR_W-1:0] off_q, off_d;
    logic [CNT_W-1:0] left_q, left_d;

    logic             start_ok;
    logic [DIV_W-1:0] div_sel;
    logic             tone_hit;
    logic             tone_out;
    logic [DIV_W-1:0] tone_cnt;
    logic             on_last;
    logic             off_last;
    logic             last_beep;

    assign start_ok  = start && (beep_count != '0);
    assign div_sel   = (state_q == S_CONT) ? tone_div : div_q;
    // >= rather than == so a live divider shrinking below tcnt wraps at once
    assign tone_hit  = (tcnt_q >= div_sel);
    assign tone_out  = tone_hit ? ~out_q : out_q;
    assign tone_cnt  = tone_hit ? '0 : tcnt_q + ONE_DIV;
    assign on_last   = (on_q == '0) || (dcnt_q == on_q - ONE_DUR);
    assign off_last  = (dcnt_q == off_q - ONE_DUR);
    assign last_beep = (left_q == ONE_CNT);

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tcnt_d  = tcnt_q;
        dcnt_d  = dcnt_q;
        div_d   = div_q;
        on_d    = on_q;
        off_d   = off_q;
        left_d  = left_q;
        if (stop) begin
            state_d = S_IDLE;
            out_d   = 1'b0;
            busy_d  = 1'b0;
            left_d  = '0;
            tcnt_d  = '0;
            dcnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_d = S_ON;
                        out_d   = 1'b0;
                        busy_d  = 1'b1;
                        tcnt_d  = '0;
                        dcnt_d  = '0;
                        div_d   = tone_div;
                        on_d    = on_ticks;
                        off_d   = off_ticks;
                        left_d  = beep_count;
                    end else if (buzz) begin
                        state_d = S_CONT;
                        tcnt_d  = '0;
                    end
                end
                S_CONT: begin
                    if (start_ok) begin
                        state_d = S_ON;
                        out_d   = 1'b0;
                        busy_d  = 1'b1;
                        tcnt_d  = '0;
                        dcnt_d  = '0;
                        div_d   = tone_div;
                        on_d    = on_ticks;
                        off_d   = off_ticks;
                        left_d  = beep_count;
                    end else if (!buzz) begin
                        state_d = S_IDLE;
                        out_d   = 1'b0;
                        tcnt_d  = '0;
                    end else begin
                        out_d   = tone_out;
                        tcnt_d  = tone_cnt;
                    end
                end
                S_ON: begin
                    if (on_last) begin
                        out_d  = 1'b0;
                        left_d = left_q - ONE_CNT;
                        tcnt_d = '0;
                        dcnt_d = '0;
                        if (last_beep) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (off_q == '0) begin
                            state_d = S_ON;
                        end else begin
                            state_d = S_OFF;
                        end
                    end else begin
                        dcnt_d = dcnt_q + ONE_DUR;
                        out_d  = tone_out;
                        tcnt_d = tone_cnt;
                    end
                end
                S_OFF: begin
                    out_d = 1'b0;
                    if (off_last) begin
                        state_d = S_ON;
                        tcnt_d  = '0;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d  = dcnt_q + ONE_DUR;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tcnt_q  <= '0;
            dcnt_q  <= '0;
            div_q   <= '0;
            on_q    <= '0;
            off_q   <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tcnt_q  <= tcnt_d;
            dcnt_q  <= dcnt_d;
            div_q   <= div_d;
            on_q    <= on_d;
            off_q   <= off_d;
            left_q  <= left_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign buzzer_out = out_q;

endmodule

// File: tb/tb_buzzer_pattern.sv
// Scoreboard bench for buzzer_pattern: per-edge expected {busy,done,out}
// is queued by the stimulus and compared by a negedge monitor.
module tb_buzzer_pattern;

    localparam int DIV_W = 16;
    localparam int DUR_W = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             buzz;
    logic [DIV_W-1:0] tone_div;
    logic [DUR_W-1:0] on_ticks;
    logic [DUR_W-1:0] off_ticks;
    logic [CNT_W-1:0] beep_count;
    logic             busy;
    logic             done;
    logic             buzzer_out;

    buzzer_pattern #(
        .DIV_W(DIV_W),
        .DUR_W(DUR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .buzz(buzz),
        .tone_div(tone_div),
        .on_ticks(on_ticks),
        .off_ticks(off_ticks),
        .beep_count(beep_count),
        .busy(busy),
        .done(done),
        .buzzer_out(buzzer_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] v;
        string      nm;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [2:0] act,
                         input logic [2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: busy,done,out got %b expected %b",
                     nm, act, exp);
        end
    endtask

    // Queue the expected outputs that follow the next rising edge.
    task automatic cyc(input logic b, input logic d, input logic o,
                       input string nm);
        exp_t e;
        @(posedge clk);
        e.v  = {b, d, o};
        e.nm = nm;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check(mon_e.nm, {busy, done, buzzer_out}, mon_e.v);
        end
    end

    // tone_div=1, on=8, off=4, count=2; optional stop edge or busy pokes
    task automatic run_pat(input string nm, input int stop_at,
                           input bit poke);
        logic [20:0] pat;
        pat        = 21'h0CC0CC;
        tone_div   = 16'd1;
        on_ticks   = 16'd8;
        off_ticks  = 16'd4;
        beep_count = 4'd2;
        start      = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, {nm, "_e0"});
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            stop = (k == stop_at);
            if (poke && k == 5) begin
                start      = 1'b1;
                buzz       = 1'b1;
                tone_div   = 16'd0;
                on_ticks   = 16'd1;
                beep_count = 4'd7;
            end
            if (poke && k == 6) start = 1'b0;
            if (poke && k == 11) buzz = 1'b0;
            if (stop_at != 0 && k >= stop_at) begin
                cyc(1'b0, 1'b0, 1'b0, $sformatf("%s_e%0d", nm, k));
                if (k == stop_at + 3) break;
            end else begin
                cyc(k < 20, k == 20, pat[k], $sformatf("%s_e%0d", nm, k));
            end
        end
        stop = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, {nm, "_idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        buzz       = 1'b0;
        tone_div   = '0;
        on_ticks   = '0;
        off_ticks  = '0;
        beep_count = '0;
        #12;
        check("reset_state", {busy, done, buzzer_out}, 3'b000);
        rst_n = 1'b1;

        // asynchronous reset while the continuous tone is high
        buzz = 1'b1;
        tick();
        tick();
        check("rst_pre_high", {busy, done, buzzer_out}, 3'b001);
        buzz  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_async", {busy, done, buzzer_out}, 3'b000);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "rst_idle");

        // legacy continuous tone
        tone_div = 16'd0;
        buzz     = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "cont_e0");
        for (int k = 1; k <= 10; k++)
            cyc(1'b0, 1'b0, k[0], $sformatf("cont_e%0d", k));
        buzz = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, "cont_off");

        run_pat("pat", 0, 1'b0);
        run_pat("abort", 5, 1'b0);
        run_pat("poke", 0, 1'b1);

        // gapless single-cycle beeps
        tone_div   = 16'd0;
        on_ticks   = 16'd0;
        off_ticks  = 16'd0;
        beep_count = 4'd3;
        start      = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, "gap_e0");
        start = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, "gap_e1");
        cyc(1'b1, 1'b0, 1'b0, "gap_e2");
        cyc(1'b0, 1'b1, 1'b0, "gap_e3");
        cyc(1'b0, 1'b0, 1'b0, "gap_e4");

        // zero beep count is ignored
        beep_count = 4'd0;
        start      = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "zero_e0");
        start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, "zero_e1");

        // stop beats start
        beep_count = 4'd2;
        start      = 1'b1;
        stop       = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "ss_e0");
        start = 1'b0;
        stop  = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, "ss_e1");

        // start during CONT, buzz ignored until the pattern completes
        tone_div = 16'd0;
        buzz     = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "sc_e0");
        cyc(1'b0, 1'b0, 1'b1, "sc_e1");
        cyc(1'b0, 1'b0, 1'b0, "sc_e2");
        on_ticks   = 16'd4;
        off_ticks  = 16'd0;
        beep_count = 4'd1;
        start      = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, "sc_e3");
        start = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, "sc_e4");
        cyc(1'b1, 1'b0, 1'b0, "sc_e5");
        cyc(1'b1, 1'b0, 1'b1, "sc_e6");
        cyc(1'b0, 1'b1, 1'b0, "sc_e7");
        cyc(1'b0, 1'b0, 1'b0, "sc_e8");
        cyc(1'b0, 1'b0, 1'b1, "sc_e9");
        buzz = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, "sc_e10");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain: got %0d left expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
